// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants.
package riscv_pkg;
  localparam int XLEN    = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with clear; head is read straight from storage flops, push/pop act at the edge.
// No internal backpressure: push while full without a pop, or pop while empty, is illegal.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst || clr) !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst || clr) !(pop && empty));
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch control: in-order imem requests at pc_q, {pc, instr} queued for decode; request->dec_valid is 2 cycles.
// Issue stalls while queued + in-flight entries reach DEPTH; decode backpressure holds the queue head.
module fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_q,
  output logic [XLEN-1:0] pc_d,
  output logic            pc_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc
);
  fetch_entry_t     q_push_dat, q_head;
  logic [XLEN-1:0]  tag_head;
  logic [CNT_W-1:0] q_count, tag_count;
  logic             q_full, q_empty, tag_full, tag_empty;
  logic [CNT_W-1:0] out_q, out_d, drop_q, drop_d;
  logic [CNT_W:0]   credit_used;
  logic             can_issue, req_fire, rsp_keep, dec_fire;

  assign credit_used = {1'b0, q_count} + {1'b0, out_q};
  assign can_issue   = (credit_used < (CNT_W + 1)'(DEPTH)) && !redirect_valid && !rst;
  assign req_fire    = can_issue && imem_req_ready;

  assign imem_req_valid = can_issue;
  assign imem_req_addr  = pc_q;
  assign pc_en          = !rst && (redirect_valid || req_fire);
  assign pc_d           = redirect_valid ? redirect_pc : pc_q + XLEN'(PC_STEP);

  // Responses landing during a redirect, or while stale ones are still owed, never reach the queue.
  assign rsp_keep   = imem_rsp_valid && !redirect_valid && (drop_q == '0) && !rst;
  assign q_push_dat = '{pc: tag_head, instr: imem_rsp_data};

  assign dec_valid = !q_empty && !rst;
  assign dec_fire  = dec_valid && dec_ready;
  assign dec_instr = q_head.instr;
  assign dec_pc    = q_head.pc;

  always_comb begin
    out_d = out_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    if (redirect_valid)
      drop_d = out_q - CNT_W'(imem_rsp_valid);
    else if (imem_rsp_valid && (drop_q != '0))
      drop_d = drop_q - 1'b1;
    else
      drop_d = drop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fetch_q (
    .clk     (clk),
    .rst     (rst),
    .clr     (redirect_valid),
    .push    (rsp_keep),
    .push_dat(q_push_dat),
    .pop     (dec_fire),
    .head_dat(q_head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  // Tags survive redirects: stale responses still pop their issued address to stay aligned.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .clr     (1'b0),
    .push    (req_fire),
    .push_dat(pc_q),
    .pop     (imem_rsp_valid && !rst),
    .head_dat(tag_head),
    .full    (tag_full),
    .empty   (tag_empty),
    .count   (tag_count)
  );

  a_out_max:    assert property (@(posedge clk) disable iff (rst) out_q <= CNT_W'(DEPTH));
  a_drop_le:    assert property (@(posedge clk) disable iff (rst) drop_q <= out_q);
  a_credit:     assert property (@(posedge clk) disable iff (rst) credit_used <= (CNT_W + 1)'(DEPTH));
  a_rsp_legal:  assert property (@(posedge clk) disable iff (rst) !(imem_rsp_valid && out_q == '0));
  a_tag_track:  assert property (@(posedge clk) disable iff (rst) tag_count == out_q);
  a_tag_push:   assert property (@(posedge clk) disable iff (rst) !(req_fire && tag_full));
  a_tag_pop:    assert property (@(posedge clk) disable iff (rst) !(imem_rsp_valid && tag_empty));
  a_q_overflow: assert property (@(posedge clk) disable iff (rst || redirect_valid) !(rsp_keep && q_full && !dec_fire));
endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: owns the PC register and an in-order memory, models fetch epochs,
// and checks decode output against a scoreboard of issued {pc, instr} entries.
`timescale 1ns/1ps
module tb_fetch_ctrl;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_q, pc_d, redirect_pc, imem_req_addr, imem_rsp_data, dec_instr, dec_pc;
  logic        pc_en, redirect_valid, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        dec_valid, dec_ready;

  always #5 clk = ~clk;

  fetch_ctrl #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_q          (pc_q),
    .pc_d          (pc_d),
    .pc_en         (pc_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_instr     (dec_instr),
    .dec_pc        (dec_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          epoch;
    int          due;
  } txn_t;

  txn_t        exp_q[$];   // every issued fetch, in issue order
  txn_t        pend_q[$];  // requests the memory still owes a response for
  int          n_vec = 0, n_err = 0, n_dec = 0;
  int          cyc = 0, epoch = 0, model_queued = 0, rst_left = 0;
  logic [31:0] model_addr, reset_pc;
  int          p_ready, max_lat, p_dec, p_redir, p_rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic knobs(input int rdy, input int lat, input int dec, input int redir, input int rs);
    p_ready = rdy; max_lat = lat; p_dec = dec; p_redir = redir; p_rst = rs;
  endtask

  task automatic step();
    logic        rs, redir, rsp, exp_rv, fire, dfire, en_s;
    logic [31:0] rpc, pcd_s;
    txn_t        t;
    @(negedge clk);
    rs    = rst;
    redir = redirect_valid;
    rsp   = imem_rsp_valid;
    rpc   = redirect_pc;
    exp_rv = !rs && !redir && (pend_q.size() + model_queued < DEPTH);
    fire   = exp_rv && imem_req_ready;
    chk("req_valid", imem_req_valid, exp_rv);
    chk("pc_en", pc_en, !rs && (redir || fire));
    if (!rs && redir) chk("pc_d_redirect", pc_d, rpc);
    if (fire) begin
      chk("req_addr", imem_req_addr, model_addr);
      chk("pc_d_step", pc_d, model_addr + 32'd4);
      t.pc    = model_addr;
      t.instr = $urandom;
      t.epoch = epoch;
      t.due   = cyc + 1 + $urandom_range(0, max_lat);
      exp_q.push_back(t);
      pend_q.push_back(t);
    end
    chk("dec_valid", dec_valid, !rs && model_queued > 0);
    dfire = !rs && dec_valid && dec_ready;
    en_s  = pc_en;
    pcd_s = pc_d;

    @(posedge clk);
    #1;
    cyc++;
    if (rsp && pend_q.size() > 0) begin
      t = pend_q.pop_front();
      if (!rs && !redir && t.epoch == epoch) model_queued++;
    end
    if (dfire && model_queued > 0) model_queued--;
    if (rs) begin
      pend_q.delete();
      model_queued = 0;
      epoch++;
      model_addr = reset_pc;
    end else if (redir) begin
      model_queued = 0;
      epoch++;
      model_addr = rpc;
    end else if (fire) begin
      model_addr = model_addr + 32'd4;
    end
    pc_q = rs ? reset_pc : (en_s ? pcd_s : pc_q);

    rst = (rst_left > 0) || ($urandom_range(0, 999) < p_rst);
    if (rst_left > 0) rst_left--;
    redirect_valid = ($urandom_range(0, 99) < p_redir);
    redirect_pc    = ($urandom_range(0, 1) == 1 ? 32'hFFFF_FF00 : 32'h0000_0100)
                     | ($urandom_range(0, 63) << 2);
    imem_req_ready = ($urandom_range(0, 99) < p_ready);
    dec_ready      = ($urandom_range(0, 99) < p_dec);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (!rst && pend_q.size() > 0) begin
      if (pend_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend_q[0].instr;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Decode-side monitor: the head must always be the oldest live-epoch fetch.
  always @(negedge clk) begin
    txn_t tmp;
    if (!rst && dec_valid) begin
      while (exp_q.size() > 0 && exp_q[0].epoch != epoch) tmp = exp_q.pop_front();
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL dec_unexpected: got pc %h with nothing outstanding (cycle %0d)", dec_pc, cyc);
      end else begin
        chk("dec_pc", dec_pc, exp_q[0].pc);
        chk("dec_instr", dec_instr, exp_q[0].instr);
        if (dec_ready) begin
          tmp = exp_q.pop_front();
          n_dec++;
        end
      end
    end
  end

  initial begin
    reset_pc       = 32'h0000_0000;
    model_addr     = reset_pc;
    pc_q           = reset_pc;
    rst            = 1'b1;
    rst_left       = 1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    dec_ready      = 1'b1;

    knobs(100, 0, 100, 0, 0); run(24);
    knobs(100, 0,   0, 0, 0); run(10);
    knobs(100, 0, 100, 0, 0); run(10);
    knobs( 80, 3,  70, 8, 0); run(400);
    reset_pc = 32'hFFFF_FFF8;
    rst_left = 2;
    knobs(100, 0, 100, 0, 0); run(12);
    knobs(100, 0, 100, 25, 0); run(60);
    knobs( 70, 2,  60, 5, 4); run(600);

    chk("dec_progress", n_dec >= 100, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
